nc_encode_dispatch: RTL and testbench

NC_ENCODE_DISPATCH -- requirements
Module: nc_encode_dispatch

---
 rtl/nc_encode_dispatch.sv | 146 ++++++++++++++
 tb/tb_nc_encode_dispatch.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nc_encode_dispatch.sv
// nc_encode_dispatch: issues one XOR-coded flit (W_data ^ E_data) to the
// direction set chosen by the encoding rules, then pops both head flits.
// Ports: clk/rst (sync, active-high); W_/E_valid, W_/E_data, if_sat and
// Forward_directions from the encoder front end; Out_ready/Out_valid,
// Out_data, Out_coded to routers; W_pop/E_pop to input buffers;
// nc_abort timeout pulse; busy while not IDLE.
// Direction bit order: IP=0, W=1, E=2, S=3, N=4, D=5, U=6.
module nc_encode_dispatch #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15,
  parameter int BACKOFF    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  W_valid,
  input  logic                  E_valid,
  input  logic [DATA_WIDTH-1:0] W_data,
  input  logic [DATA_WIDTH-1:0] E_data,
  input  logic                  if_sat,
  input  logic [6:0]            Forward_directions,
  input  logic [6:0]            Out_ready,
  output logic [6:0]            Out_valid,
  output logic [DATA_WIDTH-1:0] Out_data,
  output logic                  Out_coded,
  output logic                  W_pop,
  output logic                  E_pop,
  output logic                  nc_abort,
  output logic                  busy
);

  localparam int IDX_IP = 0;
  localparam logic [6:0] IP_BIT = 7'b1 << IDX_IP;

  localparam int WCL = $clog2(MAX_WAIT + 1);
  localparam int WW  = (WCL > 4) ? WCL : 4;
  localparam int BCL = $clog2(BACKOFF + 1);
  localparam int BW  = (BCL > 4) ? BCL : 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    POP  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [6:0]            mask;
  logic [6:0]            sent;
  logic [WW-1:0]         wait_cnt;
  logic [BW-1:0]         backoff;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  abort_q;

  logic [6:0] dirs_m;
  logic [6:0] hs;
  logic [6:0] sent_nx;
  logic       launch;
  logic       timeout;

  assign dirs_m  = Forward_directions & ~IP_BIT;
  assign launch  = (state == IDLE) & W_valid & E_valid & if_sat
                 & (|dirs_m) & (backoff == '0);
  assign hs      = Out_valid & Out_ready;
  assign sent_nx = sent | hs;
  // A handshake in the timeout cycle takes priority over the abort.
  assign timeout = (state == SEND) && (sent == '0) && (hs == '0)
                 && (wait_cnt == WW'(MAX_WAIT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (launch) state_nx = SEND;
      SEND: begin
        if (sent_nx == mask) state_nx = POP;
        else if (timeout)    state_nx = IDLE;
      end
      POP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Out_valid = '0;
    Out_coded = 1'b0;
    W_pop     = 1'b0;
    E_pop     = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      SEND: begin
        Out_valid = mask & ~sent & ~IP_BIT;
        Out_coded = 1'b1;
      end
      POP: begin
        W_pop = 1'b1;
        E_pop = 1'b1;
      end
      default: ;
    endcase
  end

  assign Out_data = data_q;
  assign nc_abort = abort_q;

  // Datapath: direction mask, sent tracking, wait and backoff counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= '0;
      sent     <= '0;
      wait_cnt <= '0;
      backoff  <= '0;
      data_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= timeout;
      unique case (state)
        IDLE: begin
          if (launch) begin
            mask     <= dirs_m;
            data_q   <= W_data ^ E_data;
            sent     <= '0;
            wait_cnt <= '0;
          end else if (backoff != '0) begin
            backoff <= backoff - 1'b1;
          end
        end
        SEND: begin
          sent <= sent_nx;
          if ((sent == '0) && (wait_cnt != '1))
            wait_cnt <= wait_cnt + 1'b1;
          if (timeout)
            backoff <= BW'(BACKOFF);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nc_encode_dispatch.sv
// Directed bench for nc_encode_dispatch with a coded-data scoreboard.
// Ports: none (top-level bench).
module tb_nc_encode_dispatch;

  localparam logic [6:0] DIP = 7'h01;
  localparam logic [6:0] DE  = 7'h04;
  localparam logic [6:0] DS  = 7'h08;
  localparam logic [6:0] DN  = 7'h10;
  localparam logic [6:0] DD  = 7'h20;
  localparam logic [6:0] DU  = 7'h40;
  localparam logic [6:0] ALL = 7'h7f;

  logic        clk = 1'b0;
  logic        rst;
  logic        W_valid, E_valid, if_sat;
  logic [31:0] W_data, E_data;
  logic [6:0]  Forward_directions, Out_ready;
  logic [6:0]  Out_valid;
  logic [31:0] Out_data;
  logic        Out_coded, W_pop, E_pop, nc_abort, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] tmp;

  always #5 clk = ~clk;

  nc_encode_dispatch #(
    .DATA_WIDTH(32), .MAX_WAIT(15), .BACKOFF(8)
  ) dut (
    .clk(clk), .rst(rst),
    .W_valid(W_valid), .E_valid(E_valid),
    .W_data(W_data), .E_data(E_data),
    .if_sat(if_sat),
    .Forward_directions(Forward_directions),
    .Out_ready(Out_ready), .Out_valid(Out_valid),
    .Out_data(Out_data), .Out_coded(Out_coded),
    .W_pop(W_pop), .E_pop(E_pop),
    .nc_abort(nc_abort), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: coded payload is checked while offered and on pop.
  task automatic mon();
    chk("ip_bit", 64'(Out_valid[0]), 64'(0));
    if (|Out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_empty observed=%0h expected=none", Out_data);
      end else begin
        chk("data", 64'(Out_data), 64'(sb[0]));
      end
    end
    if (W_pop) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL pop_unexp observed=1 expected=0");
      end else begin
        chk("pop_data", 64'(Out_data), 64'(sb[0]));
        tmp = sb.pop_front();
      end
    end
    if (nc_abort && sb.size() != 0) tmp = sb.pop_front();
  endtask

  task automatic st(input string tag, input logic b,
                    input logic [6:0] v, input logic p,
                    input logic a);
    chk({tag, ".busy"},  64'(busy),      64'(b));
    chk({tag, ".valid"}, 64'(Out_valid), 64'(v));
    chk({tag, ".coded"}, 64'(Out_coded), 64'(b & ~p));
    chk({tag, ".wpop"},  64'(W_pop),     64'(p));
    chk({tag, ".epop"},  64'(E_pop),     64'(p));
    chk({tag, ".abort"}, 64'(nc_abort),  64'(a));
    mon();
  endtask

  task automatic load(input logic [31:0] w, input logic [31:0] e,
                      input logic [6:0] d, input bit exp_launch);
    W_valid = 1'b1;
    E_valid = 1'b1;
    if_sat  = 1'b1;
    W_data  = w;
    E_data  = e;
    Forward_directions = d;
    if (exp_launch) sb.push_back(w ^ e);
  endtask

  task automatic drop();
    W_valid = 1'b0;
    E_valid = 1'b0;
    if_sat  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drop();
    W_data = '0;
    E_data = '0;
    Forward_directions = '0;
    Out_ready = '0;
    nxt();
    nxt();
    smp();
    st("reset", 0, 0, 0, 0);
    chk("reset.data", 64'(Out_data), 64'(0));
    nxt();
    rst = 1'b0;
    smp();
    st("idle0", 0, 0, 0, 0);

    // All-ready single-cycle dispatch
    nxt();
    load(32'hA5A5_0000, 32'h0000_5A5A, DN | DU, 1);
    Out_ready = ALL;
    smp();
    st("t1_launch", 0, 0, 0, 0);
    nxt();
    smp();
    st("t1_send", 1, DN | DU, 0, 0);
    chk("t1_xor", 64'(Out_data), 64'(32'hA5A5_5A5A));
    nxt();
    smp();
    st("t1_pop", 1, 0, 1, 0);
    nxt();
    drop();
    smp();
    st("t1_idle", 0, 0, 0, 0);

    // Staggered readiness
    nxt();
    load(32'h1234_5678, 32'h0F0F_0F0F, DN | DU, 1);
    Out_ready = '0;
    smp();
    st("t2_launch", 0, 0, 0, 0);
    nxt();
    Out_ready = DN;
    smp();
    st("t2_c1", 1, DN | DU, 0, 0);
    nxt();
    Out_ready = '0;
    smp();
    st("t2_c2", 1, DU, 0, 0);
    nxt();
    smp();
    st("t2_c3", 1, DU, 0, 0);
    nxt();
    Out_ready = DU;
    smp();
    st("t2_c4", 1, DU, 0, 0);
    nxt();
    Out_ready = '0;
    smp();
    st("t2_pop", 1, 0, 1, 0);
    nxt();
    drop();
    smp();
    st("t2_idle", 0, 0, 0, 0);

    // Timeout abort, backoff, relaunch
    nxt();
    load(32'hDEAD_BEEF, 32'h0000_FFFF, DS | DD, 1);
    Out_ready = '0;
    smp();
    st("t3_launch", 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      nxt();
      smp();
      st("t3_wait", 1, DS | DD, 0, 0);
    end
    nxt();
    smp();
    st("t3_abort", 0, 0, 0, 1);
    sb.push_back(32'hDEAD_BEEF ^ 32'h0000_FFFF);
    for (int i = 2; i <= 9; i++) begin
      nxt();
      smp();
      st("t3_backoff", 0, 0, 0, 0);
    end
    nxt();
    Out_ready = ALL;
    smp();
    st("t3_relaunch", 1, DS | DD, 0, 0);
    nxt();
    smp();
    st("t3_pop", 1, 0, 1, 0);
    nxt();
    drop();
    smp();
    st("t3_idle", 0, 0, 0, 0);

    // IP bit masking
    nxt();
    load(32'h0000_00FF, 32'h0000_0F00, DE | DIP, 1);
    Out_ready = ALL;
    smp();
    st("t4_launch", 0, 0, 0, 0);
    nxt();
    smp();
    st("t4_send", 1, DE, 0, 0);
    nxt();
    smp();
    st("t4_pop", 1, 0, 1, 0);
    nxt();
    load(32'h1111_1111, 32'h2222_2222, DIP, 0);
    smp();
    st("t4_iponly", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp();
      st("t4_nolaunch", 0, 0, 0, 0);
    end
    nxt();
    drop();

    // Reset mid-SEND after one direction sent
    load(32'hCAFE_0000, 32'h0000_BABE, DN | DU, 1);
    Out_ready = DN;
    smp();
    st("t5_launch", 0, 0, 0, 0);
    nxt();
    smp();
    st("t5_c1", 1, DN | DU, 0, 0);
    nxt();
    Out_ready = '0;
    rst = 1'b1;
    smp();
    st("t5_c2", 1, DU, 0, 0);
    nxt();
    rst = 1'b0;
    sb.delete();
    load(32'hCAFE_0000, 32'h0000_BABE, DN | DU, 1);
    smp();
    st("t5_rst", 0, 0, 0, 0);
    chk("t5_rst.data", 64'(Out_data), 64'(0));
    nxt();
    Out_ready = ALL;
    smp();
    st("t5_resend", 1, DN | DU, 0, 0);
    nxt();
    smp();
    st("t5_pop", 1, 0, 1, 0);
    nxt();
    drop();
    smp();
    st("t5_idle", 0, 0, 0, 0);

    // Handshake on the timeout cycle wins
    nxt();
    load(32'h8000_0001, 32'h7FFF_FFFE, DN | DU, 1);
    Out_ready = '0;
    smp();
    st("t6_launch", 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      nxt();
      smp();
      st("t6_wait", 1, DN | DU, 0, 0);
    end
    nxt();
    Out_ready = DN;
    smp();
    st("t6_edge", 1, DN | DU, 0, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      Out_ready = '0;
      smp();
      st("t6_hold", 1, DU, 0, 0);
    end
    nxt();
    Out_ready = DU;
    smp();
    st("t6_last", 1, DU, 0, 0);
    nxt();
    Out_ready = '0;
    smp();
    st("t6_pop", 1, 0, 1, 0);
    nxt();
    drop();
    smp();
    st("t6_idle", 0, 0, 0, 0);

    chk("sb_drain", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
